// File: rtl/de_reg_stall_if.sv
// D-to-E pipeline bundle: D-stage operands in, E-stage registers, stall and counter out.
// The pipeline side uses the master modport and de_reg_stall uses the slave modport.
interface de_reg_stall_if;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [31:0] d_rs_val;
    logic [31:0] d_rt_val;
    logic [31:0] d_imm32;
    logic        md_busy;
    logic        stall;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_rs_val;
    logic [31:0] e_rt_val;
    logic [31:0] e_imm32;
    logic        e_valid;
    logic [31:0] stall_cnt;

    modport master (
        output d_instr, d_pc, d_rs_val, d_rt_val, d_imm32, md_busy,
        input  stall, e_instr, e_pc, e_rs_val, e_rt_val, e_imm32, e_valid, stall_cnt
    );

    modport slave (
        input  d_instr, d_pc, d_rs_val, d_rt_val, d_imm32, md_busy,
        output stall, e_instr, e_pc, e_rs_val, e_rt_val, e_imm32, e_valid, stall_cnt
    );
endinterface

// File: rtl/de_reg_stall.sv
// D/E pipeline register with load-use and mult/div hazard detection and bubble insertion.
// Define DE_STALL_CNT_EN to build a saturating stalled-cycle counter; otherwise stall_cnt is 0.
module de_reg_stall (
    input  logic           clk,
    input  logic           reset,
    de_reg_stall_if.slave  bus
);
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm32;
        logic        valid;
    } e_stage_t;

    localparam logic [5:0] OP_LW = 6'h23;

    e_stage_t e_q;
    e_stage_t d_stage;
    logic     lu_hazard;
    logic     md_hazard;
    logic     stall_w;

    function automatic logic is_md_class(input logic [31:0] ins);
        return (ins[31:26] == 6'h00) &&
               (ins[5:0] inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B});
    endfunction

    // A bubble never hazards, and a load into $0 never produces a value worth waiting for.
    assign lu_hazard = e_q.valid && (e_q.instr[31:26] == OP_LW) &&
                       (e_q.instr[20:16] != 5'd0) &&
                       ((e_q.instr[20:16] == bus.d_instr[25:21]) ||
                        (e_q.instr[20:16] == bus.d_instr[20:16]));
    assign md_hazard = is_md_class(bus.d_instr) && bus.md_busy;
    assign stall_w   = lu_hazard || md_hazard;

    assign d_stage = '{instr:  bus.d_instr,
                       pc:     bus.d_pc,
                       rs_val: bus.d_rs_val,
                       rt_val: bus.d_rt_val,
                       imm32:  bus.d_imm32,
                       valid:  1'b1};

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
        end else if (stall_w) begin
            e_q <= '0;
        end else begin
            e_q <= d_stage;
        end
    end

`ifdef DE_STALL_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (stall_w && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign bus.stall_cnt = cnt_q;
`else
    assign bus.stall_cnt = 32'h0;
`endif

    assign bus.stall    = stall_w;
    assign bus.e_instr  = e_q.instr;
    assign bus.e_pc     = e_q.pc;
    assign bus.e_rs_val = e_q.rs_val;
    assign bus.e_rt_val = e_q.rt_val;
    assign bus.e_imm32  = e_q.imm32;
    assign bus.e_valid  = e_q.valid;
endmodule
